// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD = 1'b1;
  localparam int CNT_W = 3;
endpackage

// File: rtl/mem_arb_wait_cnt.sv
// mem_arb_wait_cnt: loadable wait-state down-counter with zero flag.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] init,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= init;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: cpu/loader arbiter for one memory port; define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          owner,
  output logic          busy
);
  state_t state;
  logic we_q, win, start, cnt_zero;
  assign start = state == IDLE && (cpu_req || ld_req);
`ifdef MEM_ARB_RR_EN
  // on a tie the master that did not own the last transfer goes next
  assign win = (cpu_req && ld_req) ? ~owner : (ld_req ? OWN_LD : OWN_CPU);
`else
  assign win = ld_req ? OWN_LD : OWN_CPU;
`endif
  mem_arb_wait_cnt u_cnt (
    .clk  (clk),
    .reset(reset),
    .load (start),
    .en   (state == ACCESS),
    .init (CNT_W'(WAIT)),
    .zero (cnt_zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            state     <= ACCESS;
            owner     <= win;
            we_q      <= win == OWN_LD ? ld_we : cpu_we;
            mem_addr  <= win == OWN_LD ? ld_addr : cpu_addr;
            mem_wdata <= win == OWN_LD ? ld_wdata : cpu_wdata;
          end
        ACCESS:
          if (cnt_zero) begin
            state <= DONE;
            if (!we_q && owner == OWN_LD) ld_rdata <= mem_rdata;
            if (!we_q && owner == OWN_CPU) cpu_rdata <= mem_rdata;
          end
        default: state <= IDLE;
      endcase
    end
  assign mem_en  = state == ACCESS;
  assign mem_wr  = state == ACCESS && we_q;
  assign busy    = state != IDLE;
  assign cpu_ack = state == DONE && owner == OWN_CPU;
  assign ld_ack  = state == DONE && owner == OWN_LD;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at WAIT=1, 0 and 3.
module tb_mem_arbiter;
  localparam int W = 1;
  logic clk = 0, reset, r3, cpu_req, cpu_we, ld_req, ld_we, z_req, t_req;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata;
  logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
  logic cpu_ack, ld_ack, mem_en, mem_wr, owner, busy;
  logic [15:0] z_cpu_rdata, z_ld_rdata, z_mem_addr, z_mem_wdata;
  logic z_cpu_ack, z_ld_ack, z_mem_en, z_mem_wr, z_owner, z_busy;
  logic [15:0] t_cpu_rdata, t_ld_rdata, t_mem_addr, t_mem_wdata;
  logic t_cpu_ack, t_ld_ack, t_mem_en, t_mem_wr, t_owner, t_busy;
  int checks = 0, errors = 0;
  logic [1:0] seq [4];
  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16), .WAIT(W)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .ld_req(ld_req),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_en(mem_en),
    .mem_wr(mem_wr), .owner(owner), .busy(busy));

  mem_arbiter #(.AW(16), .DW(16), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .cpu_req(1'b0), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack), .ld_req(z_req),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(z_ld_rdata), .ld_ack(z_ld_ack),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .mem_en(z_mem_en),
    .mem_wr(z_mem_wr), .owner(z_owner), .busy(z_busy));

  mem_arbiter #(.AW(16), .DW(16), .WAIT(3)) dut3 (
    .clk(clk), .reset(r3), .cpu_req(t_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(t_cpu_rdata), .cpu_ack(t_cpu_ack), .ld_req(1'b0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(t_ld_rdata), .ld_ack(t_ld_ack),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata), .mem_en(t_mem_en),
    .mem_wr(t_mem_wr), .owner(t_owner), .busy(t_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(cpu_ack || ld_ack) && n < 20);
    chk("ack_seen", 32'(cpu_ack | ld_ack), 1);
    chk("one_ack", 32'(cpu_ack & ld_ack), 0);
  endtask

  initial begin
    int n;
    reset = 1; r3 = 1;
    {cpu_req, cpu_we, ld_req, ld_we, z_req, t_req} = '0;
    {cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata} = '0;
    tick(); tick();
    chk("reset_data", {mem_addr, mem_wdata}, 0);
    chk("reset_rdata", {cpu_rdata, ld_rdata}, 0);
    chk("reset_ctl", {cpu_ack, ld_ack, mem_en, mem_wr, owner, busy}, 0);
    reset = 0; r3 = 0;
    tick();
    // cpu read, WAIT=1
    cpu_addr = 16'h0010; mem_rdata = 16'hBEEF; cpu_req = 1;
    tick();
    chk("rd_acc1", {mem_en, mem_wr, busy, owner}, 4'b1010);
    chk("rd_addr", mem_addr, 16'h0010);
    tick();
    chk("rd_acc2", {mem_en, mem_wr, cpu_ack, ld_ack}, 4'b1000);
    tick();
    chk("rd_done", {mem_en, cpu_ack, ld_ack, busy}, 4'b0101);
    chk("rd_data", cpu_rdata, 16'hBEEF);
    cpu_req = 0;
    tick();
    chk("rd_idle", {cpu_ack, ld_ack, busy}, 0);
    // address changes and req drops mid-transfer
    cpu_addr = 16'h0020; mem_rdata = 16'h5555; cpu_req = 1;
    tick();
    cpu_addr = 16'h0030; cpu_req = 0;
    chk("chg_addr1", mem_addr, 16'h0020);
    tick();
    chk("chg_addr2", {mem_en, mem_addr}, {1'b1, 16'h0020});
    tick();
    chk("chg_ack", {cpu_ack, mem_addr}, {1'b1, 16'h0020});
    chk("chg_data", cpu_rdata, 16'h5555);
    tick(); tick();
    chk("chg_idle", {busy, cpu_ack}, 0);
    // cpu write keeps rdata
    cpu_addr = 16'h0040; cpu_wdata = 16'hA5A5; cpu_we = 1; mem_rdata = 16'h1111; cpu_req = 1;
    tick();
    chk("wr_strobe", {mem_en, mem_wr, mem_wdata}, {2'b11, 16'hA5A5});
    tick(); tick();
    chk("wr_ack", cpu_ack, 1);
    chk("wr_rdata_kept", cpu_rdata, 16'h5555);
    cpu_req = 0; cpu_we = 0;
    tick();
    // loader write, WAIT=0
    ld_addr = 16'h0100; ld_wdata = 16'h1234; ld_we = 1; z_req = 1;
    tick();
    chk("z_acc", {z_mem_en, z_mem_wr, z_owner, z_busy, z_ld_ack}, 5'b11110);
    chk("z_bus", {z_mem_addr, z_mem_wdata}, {16'h0100, 16'h1234});
    tick();
    chk("z_done", {z_ld_ack, z_cpu_ack, z_mem_en, z_mem_wr}, 4'b1000);
    chk("z_rdata_kept", z_ld_rdata, 0);
    z_req = 0;
    tick();
    chk("z_idle", {z_busy, z_ld_ack}, 0);
    // simultaneous requests; {cpu_ack, ld_ack} expected per transfer
`ifdef MEM_ARB_RR_EN
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    seq = '{2'b01, 2'b01, 2'b01, 2'b10};
`endif
    ld_we = 0; ld_addr = 16'h0200; cpu_addr = 16'h0300; mem_rdata = 16'h7777;
    cpu_req = 1; ld_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      chk($sformatf("tie_who%0d", k), {cpu_ack, ld_ack}, seq[k]);
      chk($sformatf("tie_owner%0d", k), owner, seq[k][0]);
      chk($sformatf("tie_gap%0d", k), n, k == 0 ? W + 2 : W + 3);
      if (k == 2) ld_req = 0;
    end
    chk("tie_ld_rdata", ld_rdata, 16'h7777);
    cpu_req = 0;
    tick();
    // reset mid-ACCESS, WAIT=3
    cpu_addr = 16'h0050; mem_rdata = 16'h3C3C; t_req = 1;
    tick(); tick();
    chk("t_acc", {t_mem_en, t_busy}, 2'b11);
    #1 r3 = 1;
    #1 chk("t_rst_now", {t_mem_en, t_mem_wr, t_busy, t_cpu_ack, t_ld_ack, t_owner}, 0);
    chk("t_rst_addr", t_mem_addr, 0);
    tick();
    chk("t_rst_hold", {t_mem_en, t_busy, t_cpu_ack}, 0);
    r3 = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!t_cpu_ack && n < 20);
    chk("t_ack_lat", n, 5);
    chk("t_rdata", {t_cpu_ack, t_ld_ack, t_cpu_rdata}, {2'b10, 16'h3C3C});
    t_req = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory arbiter that shares the single external memory port between the cpu0 core and a program-loader/debug master. It sits between the masters' request ports and the memory, and serialises accesses through a small state machine with a configurable number of wait states. Each master sees a req/ack handshake and returns registered read data. The arbiter drives the memory address, write data and write strobe.

## Interface
- AW, 16, address width
- DW, 16, data width
- WAIT, 1, extra memory wait cycles per access, legal range 0..7

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  cpu access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  cpu address
- cpu_wdata  in  DW  cpu write data
- cpu_rdata  out  DW  registered read data to cpu
- cpu_ack  out  1  one-cycle completion pulse to cpu
- ld_req / ld_we / ld_addr / ld_wdata / ld_rdata / ld_ack: loader port, same widths and meanings as the cpu port
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid at the last ACCESS cycle
- mem_en  out  1  memory select, high during ACCESS
- mem_wr  out  1  write strobe, high during ACCESS when the latched we = 1
- owner  out  1  0 = cpu, 1 = loader; master of the current or last transfer
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS:
  - Taken when any req = 1.
  - The winner is chosen by the arbitration rule (see Configuration).
  - On the transition edge the winner's addr, wdata and we are latched into mem_addr, mem_wdata and the internal we register.
  - owner is updated on the same edge.
  - The wait counter is loaded with WAIT.
- ACCESS:
  - mem_en = 1; mem_wr = latched we.
  - The counter decrements each cycle.
  - When the counter = 0: on a read, mem_rdata is captured into the owner's rdata register; then go to DONE.
- DONE:
  - The owner's ack = 1 for exactly this cycle.
  - Then go to IDLE.
- Handshake rules:
  - A master keeps req and its qualifiers stable until ack.
  - A req still high in the cycle after ack starts a new transfer.
  - The losing master's req stays pending. It is served at the next IDLE.
- Inputs that change after the latch are ignored for the rest of that transfer.
- Dropping req mid-transfer does not abort the transfer. It completes and ack is still pulsed.
- A write leaves that master's rdata unchanged. rdata holds its value until that master's next read completes.
- Only one ack is ever high, and only in DONE.
- Reset values: FSM = IDLE, counter = 0, and all outputs = 0 (mem_addr, mem_wdata, cpu_rdata, ld_rdata, acks, mem_en, mem_wr, owner, busy).
- Reset mid-transfer: the transfer is abandoned with no ack, mem_en/mem_wr drop immediately, and the master must re-request.

## Timing
- req sampled high in IDLE at cycle N:
  - ACCESS occupies cycles N+1 .. N+1+WAIT.
  - ack is high at N+2+WAIT.
  - rdata is valid from N+2+WAIT onward.
- With WAIT = 0: ACCESS lasts 1 cycle and ack is at N+2.
- Back-to-back transfers: with req held high through ack, the next transfer latches in the IDLE cycle N+3+WAIT. Period is WAIT+3 cycles.
- mem_addr and mem_wdata are registered and stable for the whole ACCESS window. They hold their last value while idle.
- mem_en and mem_wr are decoded from registered state, so they are glitch-free.

## Configuration
- MEM_ARB_RR_EN undefined:
  - Fixed priority; the loader wins when both requests are high.
  - The cpu can starve while the loader streams.
- MEM_ARB_RR_EN defined:
  - Round-robin on simultaneous requests; the master that is not the current owner wins.
  - A single requester always wins regardless of history.
  - After reset owner = 0, so the loader wins the first tie.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - OWN_CPU = 1'b0 and OWN_LD = 1'b1;
  - the 3-bit wait-counter width constant.
- One sub-module is natural: mem_arb_wait_cnt.
  - Loadable down-counter with load, enable and zero flag.
  - Async reset to 0.

## Test plan
- Single cpu read, WAIT=1: cpu_req at N, addr 0x0010, mem returns 0xBEEF → mem_en high N+1..N+2, mem_wr 0, cpu_ack at N+3, cpu_rdata = 0xBEEF, ld_ack never.
- Loader write, WAIT=0: ld_addr 0x0100, ld_wdata 0x1234 → mem_wr/mem_en high exactly at N+1 with mem_addr = 0x0100 and mem_wdata = 0x1234; ld_ack at N+2; ld_rdata unchanged.
- Simultaneous requests, macro off, both held for 3 transfers → three loader acks and no cpu_ack; after ld_req drops, the cpu is served next.
- Simultaneous requests, macro on, both held → acks alternate ld, cpu, ld, cpu; owner toggles each transfer.
- Reset during ACCESS with WAIT=3 → outputs all 0 the same cycle, no ack; after release, a held cpu_req completes normally with ack at WAIT+2 cycles after reset deassertion.
- Requester changes cpu_addr from 0x0020 to 0x0030 during ACCESS → mem_addr stays 0x0020 until DONE, and ack is still issued.
